// File: rtl/uart_tx.sv
// uart_tx: byte-wide asynchronous serial transmitter.
//
// Sends START (0), eight data bits LSB first, an optional parity bit, then one
// or two STOP bits (1). Every bit lasts max(clock_divider_i, 1) clock cycles.
// After the last stop bit the line rests for at least two cycles (GAP) before
// another frame can start. The frame settings are captured on the start edge,
// so later input changes do not affect a frame that is already running.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_i          synchronous reset, active low
//   write_i          transmit request; one frame per low-to-high re-arm
//   two_stop_bits_i  1 = two stop bits, 0 = one
//   parity_bit_i     1 = append parity bit after data
//   parity_even_i    1 = even parity, 0 = odd
//   clock_divider_i  clock cycles per bit (0 behaves as 1)
//   data_i           byte to send
//   serial_o         TX line, idle high (registered)
//   busy_o           high while a frame is in progress or during reset (registered)
module uart_tx (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        write_i,
    input  logic        two_stop_bits_i,
    input  logic        parity_bit_i,
    input  logic        parity_even_i,
    input  logic [15:0] clock_divider_i,
    input  logic [7:0]  data_i,
    output logic        serial_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  data_q, data_d;
    logic        parity_en_q, parity_en_d;
    logic        parity_even_q, parity_even_d;
    logic        two_stop_q, two_stop_d;
    logic        serial_q, serial_d;
    logic        busy_q, busy_d;

    logic        bit_done;
    logic [2:0]  next_bit;
    logic        parity_val;

    // div_q is stored already clamped to at least 1, so the subtraction never wraps.
    assign bit_done   = (div_cnt_q == div_q - 16'd1);
    assign next_bit   = bit_cnt_q + 3'd1;
    assign parity_val = parity_even_q ? (^data_q) : ~(^data_q);

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q       <= StIdle;
            armed_q       <= 1'b0;
            bit_cnt_q     <= 3'd0;
            div_cnt_q     <= 16'd0;
            div_q         <= 16'd1;
            data_q        <= 8'd0;
            parity_en_q   <= 1'b0;
            parity_even_q <= 1'b0;
            two_stop_q    <= 1'b0;
            serial_q      <= 1'b1;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            bit_cnt_q     <= bit_cnt_d;
            div_cnt_q     <= div_cnt_d;
            div_q         <= div_d;
            data_q        <= data_d;
            parity_en_q   <= parity_en_d;
            parity_even_q <= parity_even_d;
            two_stop_q    <= two_stop_d;
            serial_q      <= serial_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        div_cnt_d     = div_cnt_q;
        div_d         = div_q;
        data_d        = data_q;
        parity_en_d   = parity_en_q;
        parity_even_d = parity_even_q;
        two_stop_d    = two_stop_q;
        serial_d      = serial_q;
        busy_d        = busy_q;
        // Any cycle with write_i low arms the next frame; a frame start consumes it.
        armed_d       = write_i ? armed_q : 1'b1;

        unique case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (write_i && armed_q) begin
                    data_d        = data_i;
                    parity_en_d   = parity_bit_i;
                    parity_even_d = parity_even_i;
                    two_stop_d    = two_stop_bits_i;
                    div_d         = (clock_divider_i == 16'd0) ? 16'd1 : clock_divider_i;
                    div_cnt_d     = 16'd0;
                    bit_cnt_d     = 3'd0;
                    armed_d       = 1'b0;
                    serial_d      = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = StStart;
                end
            end

            StStart: begin
                div_cnt_d = div_cnt_q + 16'd1;
                if (bit_done) begin
                    div_cnt_d = 16'd0;
                    bit_cnt_d = 3'd0;
                    serial_d  = data_q[0];
                    state_d   = StData;
                end
            end

            StData: begin
                div_cnt_d = div_cnt_q + 16'd1;
                if (bit_done) begin
                    div_cnt_d = 16'd0;
                    if (bit_cnt_q == 3'd7) begin
                        if (parity_en_q) begin
                            serial_d = parity_val;
                            state_d  = StParity;
                        end else begin
                            serial_d = 1'b1;
                            state_d  = StStop1;
                        end
                    end else begin
                        bit_cnt_d = next_bit;
                        serial_d  = data_q[next_bit];
                    end
                end
            end

            StParity: begin
                div_cnt_d = div_cnt_q + 16'd1;
                if (bit_done) begin
                    div_cnt_d = 16'd0;
                    serial_d  = 1'b1;
                    state_d   = StStop1;
                end
            end

            StStop1: begin
                div_cnt_d = div_cnt_q + 16'd1;
                if (bit_done) begin
                    div_cnt_d = 16'd0;
                    serial_d  = 1'b1;
                    if (two_stop_q) begin
                        state_d = StStop2;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StGap;
                    end
                end
            end

            StStop2: begin
                div_cnt_d = div_cnt_q + 16'd1;
                if (bit_done) begin
                    div_cnt_d = 16'd0;
                    serial_d  = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StGap;
                end
            end

            // Two idle-high cycles independent of the divider; div_cnt is reused.
            StGap: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (div_cnt_q == 16'd1) begin
                    div_cnt_d = 16'd0;
                    state_d   = StIdle;
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end

            default: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    assign serial_o = serial_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
//
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a cycle away from the rising edge the design uses.
module tb_uart_tx;

    logic        clock;
    logic        reset_n;
    logic        write;
    logic        two_stop;
    logic        parity_en;
    logic        parity_even;
    logic [15:0] divider;
    logic [7:0]  data;
    logic        serial;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx dut (
        .clock_i         (clock),
        .reset_i         (reset_n),
        .write_i         (write),
        .two_stop_bits_i (two_stop),
        .parity_bit_i    (parity_en),
        .parity_even_i   (parity_even),
        .clock_divider_i (divider),
        .data_i          (data),
        .serial_o        (serial),
        .busy_o          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait up to 'limit' falling edges for a start bit, then check every cycle of
    // the frame against the expected bit list, then the first gap cycle.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                                input logic pev, input logic ts, input int n,
                                input int limit);
        logic bits [12];
        int   len;
        bit   found;
        found = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (serial == 1'b0) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            check({tag, " start"}, {31'd0, serial}, 32'd0);
            return;
        end
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        len = 9;
        if (pe) begin
            bits[len] = pev ? (^d) : ~(^d);
            len++;
        end
        bits[len] = 1'b1;
        len++;
        if (ts) begin
            bits[len] = 1'b1;
            len++;
        end
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c < n; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clock);
                check($sformatf("%s bit%0d cyc%0d serial", tag, b, c), {31'd0, serial},
                      {31'd0, bits[b]});
                check($sformatf("%s bit%0d cyc%0d busy", tag, b, c), {31'd0, busy}, 32'd1);
            end
        end
        @(negedge clock);
        check({tag, " gap busy"}, {31'd0, busy}, 32'd0);
        check({tag, " gap serial"}, {31'd0, serial}, 32'd1);
    endtask

    // Drop write for one cycle to re-arm, then raise it again.
    task automatic rearm();
        write = 1'b0;
        @(negedge clock);
        write = 1'b1;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check({tag, " busy"}, {31'd0, busy}, 32'd0);
            check({tag, " serial"}, {31'd0, serial}, 32'd1);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        write       = 1'b0;
        two_stop    = 1'b0;
        parity_en   = 1'b0;
        parity_even = 1'b0;
        divider     = 16'd1;
        data        = 8'h00;

        // Reset then idle
        repeat (3) @(negedge clock);
        check("reset busy", {31'd0, busy}, 32'd1);
        check("reset serial", {31'd0, serial}, 32'd1);
        reset_n = 1'b1;
        @(negedge clock);
        check("post-reset busy", {31'd0, busy}, 32'd0);
        check("post-reset serial", {31'd0, serial}, 32'd1);

        // Basic frame 0x55, divider 1, write held high
        data  = 8'h55;
        write = 1'b1;
        expect_frame("basic55", 8'h55, 1'b0, 1'b0, 1'b0, 1, 10);
        expect_quiet("held-high", 10);

        // Re-arm mid-frame: 0xAA queued while 0x55 is being sent
        data = 8'h55;
        rearm();
        fork
            expect_frame("rearm55", 8'h55, 1'b0, 1'b0, 1'b0, 1, 10);
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clock);
                    if (serial == 1'b0) begin
                        seen = 1;
                        break;
                    end
                end
                if (seen) begin
                    repeat (4) @(negedge clock);
                    write = 1'b0;
                    data  = 8'hAA;
                    @(negedge clock);
                    write = 1'b1;
                end
            end
        join
        expect_frame("rearmAA", 8'hAA, 1'b0, 1'b0, 1'b0, 1, 3);

        // Parity and stop options, divider 4, data 0x07
        divider     = 16'd4;
        data        = 8'h07;
        parity_en   = 1'b1;
        parity_even = 1'b1;
        rearm();
        expect_frame("even07", 8'h07, 1'b1, 1'b1, 1'b0, 4, 10);
        parity_even = 1'b0;
        rearm();
        expect_frame("odd07", 8'h07, 1'b1, 1'b0, 1'b0, 4, 10);
        parity_even = 1'b1;
        two_stop    = 1'b1;
        rearm();
        expect_frame("twostop07", 8'h07, 1'b1, 1'b1, 1'b1, 4, 10);

        // Divider 0 behaves as 1; divider 3
        divider   = 16'd0;
        data      = 8'hA3;
        parity_en = 1'b0;
        two_stop  = 1'b0;
        rearm();
        expect_frame("div0", 8'hA3, 1'b0, 1'b0, 1'b0, 1, 10);
        divider     = 16'd3;
        data        = 8'h3C;
        parity_en   = 1'b1;
        parity_even = 1'b0;
        rearm();
        expect_frame("div3", 8'h3C, 1'b1, 1'b0, 1'b0, 3, 10);

        // Reset mid-frame at data bit 2, divider 4, data 0x00
        divider   = 16'd4;
        data      = 8'h00;
        parity_en = 1'b0;
        rearm();
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                if (serial == 1'b0) begin
                    seen = 1;
                    break;
                end
            end
            check("midreset start seen", {31'd0, seen}, 32'd1);
            // start (4 cycles) + D0, D1 (8 cycles) -> first cycle of D2
            repeat (12) @(negedge clock);
            check("midreset pre serial", {31'd0, serial}, 32'd0);
            check("midreset pre busy", {31'd0, busy}, 32'd1);
            reset_n = 1'b0;
            @(negedge clock);
            check("midreset serial", {31'd0, serial}, 32'd1);
            check("midreset busy", {31'd0, busy}, 32'd1);
            @(negedge clock);
            check("midreset hold busy", {31'd0, busy}, 32'd1);
            reset_n = 1'b1;
        end
        expect_quiet("after-reset", 20);
        rearm();
        expect_frame("resume00", 8'h00, 1'b0, 1'b0, 1'b0, 4, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-wide asynchronous serial transmitter (8 data bits, LSB first) with optional parity and one or two stop bits.
- The baud rate is set by a runtime clock divider.
- Sits between a host/register interface and the TX pin; the host pulses or raises write_i and monitors busy_o.

Parameters:
- None. Data width is fixed at 8 and the divider at 16 bits.

Ports:
- clock_i  in  1  system clock; all logic on rising edge
- reset_i  in  1  reset
- write_i  in  1  transmit request, one-shot semantics (see Behaviour)
- two_stop_bits_i  in  1  1 = two stop bits, 0 = one
- parity_bit_i  in  1  1 = append parity bit after data
- parity_even_i  in  1  1 = even parity, 0 = odd
- clock_divider_i  in  16  clock cycles per bit; 0 treated as 1
- data_i  in  8  byte to send
- serial_o  out  1  TX line, idle high
- busy_o  out  1  high while a frame is in progress or during reset

Behaviour:
- Reset is synchronous and active-low; one clock.
- While reset is asserted:
  - serial_o = 1, busy_o = 1.
  - Internal state is forced to IDLE.
  - The write "armed" flag is cleared.
  - Bit and divider counters are zeroed.
- busy_o deasserts on the first clock after reset is released.
- Armed flag:
  - Set on any clock where write_i is sampled low.
  - Cleared when a frame starts.
  - Holding write_i high therefore sends exactly one frame.
  - Dropping write_i and raising it again, even mid-frame, queues exactly one further frame.
- Frame start: in IDLE, write_i = 1 and armed = 1 at a rising edge -> on that edge:
  - Latch data_i, parity_bit_i, parity_even_i, two_stop_bits_i and clock_divider_i.
  - serial_o <= 0 (start bit), busy_o <= 1.
- Input changes after the start edge have no effect on the current frame.
- Frame sequence: START (0), D0..D7 LSB first, optional PARITY, STOP1 (1), optional STOP2 (1). Each bit lasts exactly N = max(divider, 1) clock cycles.
- Parity value:
  - Even mode: XOR of the 8 data bits.
  - Odd mode: inverted XOR of the 8 data bits.
- After the last stop bit, enter GAP with serial_o = 1 and busy_o = 0. GAP lasts 2 clock cycles minimum, then returns to IDLE.
- No new frame may start before IDLE. A pending armed request plus write_i high starts on the first IDLE edge.
- serial_o and busy_o are registered; serial_o changes only while busy_o = 1 (any transition with busy_o low is a bug).
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, GAP. The bit counter 0..7 selects data bits.
- If reset is asserted mid-frame, the frame aborts immediately; serial_o returns high on that edge.

Test Plan:
- Reset then idle: pulse reset -> busy_o high during reset, falls one cycle after release; serial_o stays 1.
- Basic frame (divider 1, no parity, 1 stop, data 0x55, write_i held high) -> serial_o = 0,1,0,1,0,1,0,1,0,1 one cycle each; busy_o low after stop; no second frame while write_i stays high.
- Write re-arm mid-frame: as above, but at bit 3 drop write_i and set data_i = 0xAA, then raise write_i at bit 4 -> first frame still 0x55; busy_o low in gap; second frame (0xAA) start bit within 3 cycles of gap entry.
- Parity/stop options (divider 4, data 0x07, parity on, even) -> parity bit 1; with odd -> 0. two_stop_bits_i = 1 -> 8 cycles high before the gap; frame length 12 bits x 4 cycles.
- Divider 0 -> behaves as divider 1. Divider 3 -> every bit lasts exactly 3 cycles.
- Reset mid-frame (assert at data bit 2) -> serial_o = 1 and busy_o = 1 during reset; no frame resumes until write_i goes low then high.
